// File: rtl/dot_or_tx.sv
// Serial transmitter for a shared open-drain (wired-AND / DOT-OR) line, with read-back arbitration and fault detection.
// Latency: the first START cycle follows the accept edge; an intact frame lasts (DATA_W+2)*BIT_CYCLES cycles, and done pulses in the next cycle.
// Backpressure: tx_ready is high only in IDLE while the line is released; tx_valid and tx_data are ignored while busy.
module dot_or_tx #(
  parameter int DATA_W     = 8,
  parameter int BIT_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              line_oe,
  input  logic              line_i,
  output logic              busy,
  output logic              done,
  output logic              lost,
  output logic              fault
);

  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t            r_state;
  logic [CW-1:0]     r_cyc;
  logic [BW-1:0]     r_bit;
  logic [DATA_W-1:0] r_data;
  logic              r_oe;
  logic              r_done;
  logic              r_lost;
  logic              r_fault;

  state_t            w_state_nx;
  logic [CW-1:0]     w_cyc_nx;
  logic [BW-1:0]     w_bit_nx;
  logic [DATA_W-1:0] w_data_nx;
  logic              w_oe_nx;
  logic              w_done_nx;
  logic              w_lost_nx;
  logic              w_fault_nx;

  logic              w_line_low;
  logic              w_last;
  logic              w_is_lost;
  logic              w_is_fault;
  logic [BW-1:0]     w_bit_inc;
  logic              w_next_dbit;

  // Only a hard 0 counts as low; x and z are treated as a released line.
  assign w_line_low  = (line_i === 1'b0);
  assign w_last      = (r_cyc == CYC_LAST);
  // Line is checked only at the end of a bit cell, after it has had time to settle.
  assign w_is_lost   = w_last && !r_oe && w_line_low;
  assign w_is_fault  = w_last && r_oe && !w_line_low;
  assign w_bit_inc   = r_bit + 1'b1;
  assign w_next_dbit = r_data[w_bit_inc];

  assign tx_ready = (r_state == S_IDLE) && !w_line_low;
  assign busy     = (r_state != S_IDLE);
  assign line_oe  = r_oe;
  assign done     = r_done;
  assign lost     = r_lost;
  assign fault    = r_fault;

  // Next-state logic: bit-cell timing, frame sequencing and the arbitration/fault checks.
  always_comb begin
    w_state_nx = r_state;
    w_cyc_nx   = r_cyc;
    w_bit_nx   = r_bit;
    w_data_nx  = r_data;
    w_oe_nx    = r_oe;
    w_done_nx  = 1'b0;
    w_lost_nx  = 1'b0;
    w_fault_nx = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_oe_nx  = 1'b0;
        w_cyc_nx = '0;
        w_bit_nx = '0;
        if (tx_valid && tx_ready) begin
          w_data_nx  = tx_data;
          w_state_nx = S_START;
          w_oe_nx    = 1'b1;
        end
      end
      default: begin
        if (!w_last) begin
          w_cyc_nx = r_cyc + 1'b1;
        end else begin
          w_cyc_nx = '0;
          if (w_is_lost || w_is_fault) begin
            // Abandon the frame and get off the line at once.
            w_state_nx = S_IDLE;
            w_oe_nx    = 1'b0;
            w_bit_nx   = '0;
            w_lost_nx  = w_is_lost;
            w_fault_nx = w_is_fault;
          end else begin
            case (r_state)
              S_START: begin
                w_state_nx = S_DATA;
                w_bit_nx   = '0;
                w_oe_nx    = ~r_data[0];
              end
              S_DATA: begin
                if (r_bit == BIT_LAST) begin
                  w_state_nx = S_STOP;
                  w_bit_nx   = '0;
                  w_oe_nx    = 1'b0;
                end else begin
                  w_bit_nx = w_bit_inc;
                  w_oe_nx  = ~w_next_dbit;
                end
              end
              default: begin
                w_state_nx = S_IDLE;
                w_oe_nx    = 1'b0;
                w_bit_nx   = '0;
                w_done_nx  = 1'b1;
              end
            endcase
          end
        end
      end
    endcase
  end

  // State and output registers; reset releases the line and clears everything asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_cyc   <= '0;
      r_bit   <= '0;
      r_data  <= '0;
      r_oe    <= 1'b0;
      r_done  <= 1'b0;
      r_lost  <= 1'b0;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cyc   <= w_cyc_nx;
      r_bit   <= w_bit_nx;
      r_data  <= w_data_nx;
      r_oe    <= w_oe_nx;
      r_done  <= w_done_nx;
      r_lost  <= w_lost_nx;
      r_fault <= w_fault_nx;
    end
  end

endmodule

// File: tb/tb_dot_or_tx.sv
module tb_dot_or_tx;

  localparam int DW = 8;
  localparam int BC = 4;
  localparam int K_DONE  = 0;
  localparam int K_LOST  = 1;
  localparam int K_FAULT = 2;

  logic          clk;
  logic          reset_n;
  logic [DW-1:0] tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          line_oe;
  logic          line_i;
  logic          busy;
  logic          done;
  logic          lost;
  logic          fault;

  // Line environment: another node may pull low, the whole line may be held low, or the line may be dead (never goes low).
  logic mode_low;
  logic ext_low;
  logic dead;

  typedef struct {
    int          kind;
    int          len;
    logic [63:0] pat;
  } exp_t;

  exp_t sb[$];
  exp_t m_e;
  bit   cap_q[$];
  bit   cap_on;

  int n_checks;
  int n_errors;

  dot_or_tx #(.DATA_W(DW), .BIT_CYCLES(BC)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .line_oe  (line_oe),
    .line_i   (line_i),
    .busy     (busy),
    .done     (done),
    .lost     (lost),
    .fault    (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    line_i = 1'b1;
    if (mode_low || ext_low) line_i = 1'b0;
    else if (dead)           line_i = 1'b1;
    else if (line_oe)        line_i = 1'b0;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected line_oe trace of a frame, one entry per cycle from the first START cycle, cut at len cycles.
  function automatic logic [63:0] frame_pat(input logic [DW-1:0] d, input int len);
    logic [63:0] p;
    int k;
    p = '0;
    k = 0;
    for (int c = 0; c < BC; c++) begin p[k] = 1'b1; k++; end
    for (int i = 0; i < DW; i++)
      for (int c = 0; c < BC; c++) begin p[k] = ~d[i]; k++; end
    for (int c = 0; c < BC; c++) begin p[k] = 1'b0; k++; end
    for (int j = len; j < 64; j++) p[j] = 1'b0;
    return p;
  endfunction

  task automatic push_exp(input int kind, input logic [DW-1:0] d, input int len);
    exp_t e;
    e.kind = kind;
    e.len  = len;
    e.pat  = frame_pat(d, len);
    sb.push_back(e);
  endtask

  // Monitor: capture line_oe per cycle of a frame, score it when a terminal pulse appears.
  always @(negedge clk) begin
    if (!reset_n) begin
      cap_on = 1'b0;
      cap_q.delete();
    end else begin
      if (cap_on && (done || lost || fault)) begin
        logic [63:0] got;
        int kind;
        chk("pulse_onehot", 64'($countones({done, lost, fault})), 64'd1);
        chk("sb_nonempty", 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) begin
          m_e  = sb.pop_front();
          kind = done ? K_DONE : (lost ? K_LOST : K_FAULT);
          got  = '0;
          foreach (cap_q[k]) if (k < 64) got[k] = cap_q[k];
          chk("kind", 64'(kind), 64'(m_e.kind));
          chk("frame_len", 64'(cap_q.size()), 64'(m_e.len));
          chk("oe_pattern", got, m_e.pat);
          chk("end_oe", 64'(line_oe), 64'd0);
          chk("end_busy", 64'(busy), 64'd0);
        end
        cap_on = 1'b0;
      end else if (!cap_on) begin
        if (done || lost || fault) chk("stray_pulse", 64'({done, lost, fault}), 64'd0);
      end else begin
        cap_q.push_back(line_oe);
        if (!busy) chk("busy_in_frame", 64'(busy), 64'd1);
      end
      if (tx_valid && tx_ready) begin
        cap_on = 1'b1;
        cap_q.delete();
      end
    end
  end

  task automatic wait_ready(input string tag);
    bit got;
    got = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (tx_ready) begin got = 1'b1; break; end
    end
    chk(tag, 64'(got), 64'd1);
  endtask

  // Offer one payload, hold it until accepted, then withdraw; returns 1 ns into the first START cycle.
  task automatic send(input logic [DW-1:0] d);
    @(posedge clk); #1;
    tx_valid = 1'b1;
    tx_data  = d;
    wait_ready("accept");
    @(posedge clk); #1;
    tx_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    chk(tag, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    cap_on   = 1'b0;
    reset_n  = 1'b0;
    tx_valid = 1'b0;
    tx_data  = '0;
    mode_low = 1'b0;
    ext_low  = 1'b0;
    dead     = 1'b0;
    #2;
    chk("rst_oe", 64'(line_oe), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_pulses", 64'({done, lost, fault}), 64'd0);
    chk("rst_ready", 64'(tx_ready), 64'd1);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Lone driver, default frame.
    push_exp(K_DONE, 8'hA5, (DW + 2) * BC);
    send(8'hA5);
    wait_drain("drain_a5");

    // New offers while busy must not disturb the latched payload.
    push_exp(K_DONE, 8'h5A, (DW + 2) * BC);
    send(8'h5A);
    tx_valid = 1'b1;
    tx_data  = 8'hFF;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("ready_while_busy", 64'(tx_ready), 64'd0);
    tx_valid = 1'b0;
    wait_drain("drain_5a");

    // Another node pulls low during data bit 0 (a 1-bit): lost after the bit-0 sample.
    push_exp(K_LOST, 8'h01, 2 * BC);
    send(8'h01);
    repeat (4) @(posedge clk); #1;
    ext_low = 1'b1;
    repeat (4) @(posedge clk); #1;
    ext_low = 1'b0;
    wait_drain("drain_lost");

    // Dead line never follows the pull: fault after the START sample.
    dead = 1'b1;
    push_exp(K_FAULT, 8'h00, BC);
    send(8'h00);
    wait_drain("drain_fault");
    dead = 1'b0;

    // Line held low blocks acceptance; releasing it lets the offer through.
    @(posedge clk); #1;
    mode_low = 1'b1;
    tx_valid = 1'b1;
    tx_data  = 8'h77;
    repeat (5) @(negedge clk);
    chk("low_ready", 64'(tx_ready), 64'd0);
    chk("low_busy", 64'(busy), 64'd0);
    push_exp(K_DONE, 8'h77, (DW + 2) * BC);
    @(posedge clk); #1;
    mode_low = 1'b0;
    @(negedge clk);
    chk("release_ready", 64'(tx_ready), 64'd1);
    @(posedge clk); #1;
    tx_valid = 1'b0;
    @(negedge clk);
    chk("release_busy", 64'(busy), 64'd1);
    wait_drain("drain_77");

    // Back-to-back: second accept lands in the done cycle.
    push_exp(K_DONE, 8'h3C, (DW + 2) * BC);
    push_exp(K_DONE, 8'hC3, (DW + 2) * BC);
    @(posedge clk); #1;
    tx_valid = 1'b1;
    tx_data  = 8'h3C;
    wait_ready("b2b_accept1");
    @(posedge clk); #1;
    tx_data = 8'hC3;
    wait_ready("b2b_accept2");
    chk("b2b_in_done", 64'(done), 64'd1);
    @(posedge clk); #1;
    tx_valid = 1'b0;
    wait_drain("drain_b2b");

    // Reset during data bit 3 (a 0-bit, line pulled): released without a clock edge, no pulse, no resume.
    send(8'h96);
    repeat (17) @(posedge clk);
    #3;
    chk("pre_rst_oe", 64'(line_oe), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_oe", 64'(line_oe), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_pulses", 64'({done, lost, fault}), 64'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (50) @(negedge clk);
    chk("post_rst_busy", 64'(busy), 64'd0);
    chk("post_rst_oe", 64'(line_oe), 64'd0);

    // Normal operation after reset.
    push_exp(K_DONE, 8'hE1, (DW + 2) * BC);
    send(8'hE1);
    wait_drain("drain_e1");

    repeat (5) @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dot_or_tx.md
DOT_OR_TX -- requirements
Module: dot_or_tx

Interface
REQ-001 SHALL provide parameter DATA_W, default 8, meaning payload bits per frame (legal 1..16).
REQ-002 SHALL provide parameter BIT_CYCLES, default 4, meaning clock cycles per bit cell (legal >=2).
REQ-003 SHALL have one clock and an asynchronous, active-low reset.
REQ-004 SHALL provide port: clk  input  1  sole clock, rising edge.
REQ-005 SHALL provide port: reset_n  input  1  asynchronous active-low reset.
REQ-006 SHALL provide port: tx_data  input  DATA_W  payload, sampled on accept.
REQ-007 SHALL provide port: tx_valid  input  1  payload offered.
REQ-008 SHALL provide port: tx_ready  output  1  block can accept a payload.
REQ-009 SHALL provide port: line_oe  output  1  1 = pull the shared DOT-OR line low; 0 = release (high-z).
REQ-010 SHALL provide port: line_i  input  1  resolved shared line, read back.
REQ-011 SHALL provide port: busy  output  1  frame in progress.
REQ-012 SHALL provide port: done  output  1  one-cycle pulse, frame sent intact.
REQ-013 SHALL provide port: lost  output  1  one-cycle pulse, arbitration lost.
REQ-014 SHALL provide port: fault  output  1  one-cycle pulse, line failed to go low when pulled.

Function
REQ-015 SHALL treat line_i as low only when it is exactly 0 (case-equality); 1, z and x all count as released.
REQ-016 SHALL implement states IDLE, START, DATA, STOP; busy = 1 in every state except IDLE.
REQ-017 SHALL drive tx_ready = 1 only in IDLE while line_i is released; the line being low blocks acceptance.
REQ-018 SHALL accept when tx_valid and tx_ready are both 1 at a rising edge: latch tx_data; enter START.
REQ-019 SHALL send frame = start bit (low), DATA_W data bits LSB first, stop bit (released), each held exactly BIT_CYCLES cycles.
REQ-020 SHALL set line_oe = 1 for low bits and 0 for 1-bits and stop; line_oe is registered; the first START cycle is the cycle after accept.
REQ-021 SHALL use a cycle counter 0..BIT_CYCLES-1 and a bit counter 0..DATA_W-1; both wrap to 0 at each bit/state change.
REQ-022 SHALL sample line_i only in the last cycle of each bit cell (cycle counter = BIT_CYCLES-1).
REQ-023 On a sample where line_oe = 0 but line_i is low: go to IDLE next cycle, release the line, and pulse lost; the frame is abandoned.
REQ-024 On a sample where line_oe = 1 but line_i is not low: go to IDLE, release the line, and pulse fault.
REQ-025 If the STOP sample is clean: go to IDLE and pulse done in the first IDLE cycle; that cycle may accept a new payload (back-to-back).
REQ-026 SHALL assert at most one of done/lost/fault in any cycle; all three are 0 outside their pulse cycle.
REQ-027 SHALL ignore tx_valid and tx_data while busy; the latched payload is unaffected.
REQ-028 An intact frame SHALL occupy (DATA_W+2)*BIT_CYCLES cycles from the first START cycle to the last STOP cycle.

Reset
REQ-029 While reset_n = 0 SHALL immediately (asynchronously) force: state IDLE, line_oe = 0, busy = 0, done = lost = fault = 0, counters 0, payload register 0.
REQ-030 Reset mid-frame SHALL release the line immediately, with no pulse; the frame is not resumed after reset deasserts.
REQ-031 tx_ready after reset SHALL follow REQ-017 from the first clock edge with reset_n = 1.

Verification
REQ-032 Defaults. Accept 0xA5 at edge 0, line_i = line_oe inverted (lone driver) -> line_oe = 1 in cycles 1-4; bit-cell pattern from cycle 5 is 1,0,1,0,0,1,0,1 (oe 0,1,0,1,1,0,1,0), each 4 cycles; stop in cycles 37-40; done = 1 in cycle 41 only.
REQ-033 Arbitration loss. Send 0x01; force line_i = 0 during data bit 0 (a 1-bit) -> lost pulses in the cycle after the bit-0 sample; line_oe = 0 in that cycle; no done.
REQ-034 Fault. Send 0x00 with line_i held z (dead line) -> fault pulses after the START sample (cycle 5); state IDLE.
REQ-035 Bus busy / high-z idle. Hold line_i = 0 with tx_valid = 1 -> tx_ready = 0, no accept. Set line_i = z -> tx_ready = 1, accept next edge.
REQ-036 Reset mid-frame: assert reset_n = 0 during data bit 3 -> line_oe = 0 with no clock edge; busy = 0; no done/lost/fault pulse.
REQ-037 Back-to-back: hold tx_valid = 1 with 0x3C then 0xC3 -> second accept in the done cycle; second START begins the following cycle; both frames bit-exact.
